imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 32-bit RISC-V core. Owns the PC, drives the word address into the combinational instruction memory, and captures returned words into a 2-entry fetch buffer. Presents instructions to decode over a valid/ready handshake. Handles branch/jump redirects with buffer flush, end-of-memory stop and misaligned-target errors.

---
 rtl/imem_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer for the 32-bit RISC-V core.
// Owns the PC, drives the combinational instruction memory address, captures
// returned words into a 2-entry fetch buffer and hands them to decode over a
// valid/ready handshake. Handles redirects (with flush), end-of-memory stop
// and sticky misaligned-target errors.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        addr_err,
    output logic        busy
);

    // Byte address one past the last instruction word; 33 bits so the
    // comparison is exact even when the limit equals 2**32.
    localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_END   = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;

    // Two-entry fetch buffer: circular storage with head/tail pointers.
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q, count_d;

    logic pop;
    logic pop_eff;
    logic push;
    logic flush;
    logic has_space;
    logic at_limit;

    assign imem_addr = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = buf_instr[rd_ptr_q];
    assign out_pc    = buf_pc[rd_ptr_q];
    assign addr_err  = addr_err_q;
    assign busy      = (state_q == S_FETCH);

    assign pop       = out_valid && out_ready;
    assign has_space = (count_q != 2'd2) || pop;
    assign at_limit  = ({1'b0, pc_q} >= FETCH_LIMIT);

    // Next-state, PC and buffer control; redirects override everything else.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        flush      = 1'b0;
        push       = 1'b0;
        pop_eff    = pop;

        if (redirect_valid && (state_q != S_ERR)) begin
            flush   = 1'b1;
            pop_eff = 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d    = redirect_pc;
                state_d = fetch_en ? S_FETCH : S_IDLE;
            end else begin
                addr_err_d = 1'b1;
                state_d    = S_ERR;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_en) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!fetch_en) begin
                        state_d = S_IDLE;
                    end else if (at_limit) begin
                        state_d = S_END;
                    end else if (has_space) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                S_END: begin
                    state_d = S_END;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Occupancy update: a flush empties the buffer, otherwise push/pop net out.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push && !pop_eff) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop_eff) begin
            count_d = count_q - 2'd1;
        end
    end

    // Control registers: state, PC, sticky error, occupancy and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
            count_q    <= count_d;
            if (flush) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (pop_eff) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
            end
        end
    end

    // Buffer storage: capture {instruction, pc} at the tail on each fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr_q] <= imem_rdata;
            buf_pc[wr_ptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked against a queue-based
// behavioural model. Two instances (64-word and 4-word memories) share the
// stimulus; 'phase' selects which one is being checked.
module tb_imem_fetch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_END   = 2;
    localparam int M_ERR   = 3;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic [31:0] salt;
    logic        phase;

    logic [31:0] addr0, rdata0, instr0, pc0;
    logic        valid0, err0, busy0;
    logic [31:0] addr1, rdata1, instr1, pc1;
    logic        valid1, err1, busy1;

    assign rdata0 = (addr0 >> 2) ^ salt;
    assign rdata1 = (addr1 >> 2) ^ salt;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(addr0), .imem_rdata(rdata0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid0), .out_ready(out_ready),
        .out_instr(instr0), .out_pc(pc0),
        .addr_err(err0), .busy(busy0)
    );

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid1), .out_ready(out_ready),
        .out_instr(instr1), .out_pc(pc1),
        .addr_err(err1), .busy(busy1)
    );

    logic [31:0] a_addr, a_instr, a_pc;
    logic        a_valid, a_err, a_busy;
    assign a_addr  = phase ? addr1  : addr0;
    assign a_instr = phase ? instr1 : instr0;
    assign a_pc    = phase ? pc1    : pc0;
    assign a_valid = phase ? valid1 : valid0;
    assign a_err   = phase ? err1   : err0;
    assign a_busy  = phase ? busy1  : busy0;

    // Behavioural model: queue of {instr, pc}, a PC, a mode and a sticky error.
    logic [63:0] mq[$];
    logic [31:0] mpc;
    int          mode;
    logic        merr;

    int vectors;
    int miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    function automatic longint limit_bytes();
        return phase ? 64'd16 : 64'd256;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc  = 32'h0;
        mode = M_IDLE;
        merr = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        bit pop;
        bit push;
        int nmode;
        if (!rst) begin
            model_reset();
        end else begin
            pop = (mq.size() != 0) && out_ready;
            if (redirect_valid && mode != M_ERR) begin
                mq.delete();
                if (redirect_pc[1:0] == 2'b00) begin
                    mpc  = redirect_pc;
                    mode = fetch_en ? M_FETCH : M_IDLE;
                end else begin
                    merr = 1'b1;
                    mode = M_ERR;
                end
            end else begin
                push  = 1'b0;
                nmode = mode;
                if (mode == M_IDLE) begin
                    if (fetch_en) nmode = M_FETCH;
                end else if (mode == M_FETCH) begin
                    if (!fetch_en) nmode = M_IDLE;
                    else if (longint'(mpc) >= limit_bytes()) nmode = M_END;
                    else if (mq.size() < 2 || pop) push = 1'b1;
                end
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back({mem_word(mpc), mpc});
                    mpc = mpc + 32'd4;
                end
                mode = nmode;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model.
    task automatic compare_all();
        logic [63:0] head;
        check("out_valid", {31'd0, a_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            head = mq[0];
            check("out_pc", a_pc, head[31:0]);
            check("out_instr", a_instr, head[63:32]);
        end
        check("imem_addr", a_addr, mpc);
        check("addr_err", {31'd0, a_err}, {31'd0, merr});
        check("busy", {31'd0, a_busy}, {31'd0, mode == M_FETCH});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        int r;
        logic [31:0] t;
        vectors     = 0;
        miscompares = 0;
        phase       = 1'b0;
        salt        = '0;
        model_reset();

        // Reset values.
        do_reset();
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_instr", a_instr, 32'd0);
        check("rst_pc", a_pc, 32'd0);
        check("rst_addr", a_addr, 32'd0);

        // Free-running fetch: first valid after two edges, then one per cycle.
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        cycle();
        check("lat_valid_e1", {31'd0, a_valid}, 32'd0);
        check("lat_busy_e1", {31'd0, a_busy}, 32'd1);
        cycle();
        check("lat_valid_e2", {31'd0, a_valid}, 32'd1);
        check("first_pc", a_pc, 32'd0);
        for (int k = 1; k < 5; k++) begin
            cycle();
            check("stream_pc", a_pc, 32'(4 * k));
            check("stream_instr", a_instr, 32'(k));
        end

        // Backpressure: buffer fills with PCs 0,4 and fetching stops at 8.
        do_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
        repeat (7) cycle();
        check("stall_addr", a_addr, 32'd8);
        check("stall_head", a_pc, 32'd0);
        out_ready = 1'b1;
        cycle();
        check("drain_pc4", a_pc, 32'd4);
        cycle();
        check("drain_pc8", a_pc, 32'd8);
        cycle();

        // Redirect with a full buffer while decode accepts.
        do_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
        repeat (4) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        cycle();
        check("redir_valid", {31'd0, a_valid}, 32'd0);
        check("redir_addr", a_addr, 32'h40);
        redirect_valid = 1'b0;
        cycle();
        check("redir_pc40", a_pc, 32'h40);
        check("redir_instr", a_instr, 32'h10);
        cycle();
        check("redir_pc44", a_pc, 32'h44);

        // Four-word memory: stops at 16, redirect to 0 resumes.
        phase = 1'b1;
        do_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        repeat (12) cycle();
        check("end_valid", {31'd0, a_valid}, 32'd0);
        check("end_addr", a_addr, 32'd16);
        check("end_busy", {31'd0, a_busy}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("end_resume_pc", a_pc, 32'd0);
        check("end_resume_valid", {31'd0, a_valid}, 32'd1);
        repeat (3) cycle();

        // Misaligned redirect, ignored later redirect, asynchronous reset.
        phase = 1'b0;
        do_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        repeat (5) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        cycle();
        check("err_flag", {31'd0, a_err}, 32'd1);
        check("err_valid", {31'd0, a_valid}, 32'd0);
        redirect_pc = 32'h10;
        cycle();
        check("err_ignore_addr", a_addr, 32'd16);
        check("err_sticky", {31'd0, a_err}, 32'd1);
        redirect_valid = 1'b0;
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_err", {31'd0, a_err}, 32'd0);
        check("arst_addr", a_addr, 32'd0);
        compare_all();
        cycle();

        // fetch_en dropped with one entry buffered.
        do_reset();
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
        repeat (2) cycle();
        fetch_en = 1'b0;
        cycle();
        check("hold_busy", {31'd0, a_busy}, 32'd0);
        check("hold_addr", a_addr, 32'd4);
        check("hold_valid", {31'd0, a_valid}, 32'd1);
        out_ready = 1'b1;
        cycle();
        check("hold_drained", {31'd0, a_valid}, 32'd0);
        check("hold_addr2", a_addr, 32'd4);
        fetch_en = 1'b1;
        cycle();
        cycle();
        check("resume_pc", a_pc, 32'd4);

        // Randomized traffic on both memory sizes.
        for (int p = 0; p < 2; p++) begin
            phase = p[0];
            do_reset();
            salt = $urandom;
            for (int n = 0; n < 2000; n++) begin
                rst       = ($urandom_range(0, 299) != 0);
                fetch_en  = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 199);
                redirect_valid = (r < 8);
                if (r == 0) begin
                    t = ($urandom_range(0, 80) << 2) | $urandom_range(1, 3);
                    redirect_pc = t;
                end else if (r == 1) begin
                    redirect_pc = 32'hFFFF_FFFC;
                end else begin
                    t = $urandom_range(0, phase ? 6 : 70) << 2;
                    redirect_pc = t;
                end
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
